// File: rtl/updn_arb_pkg.sv
// Shared types and constants for the up/down counter arbiter.
// Optional build macro: UPDN_ARB_SATURATE_EN (saturating counter with early termination).
package updn_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Round-robin pick: a lone valid wins; on a tie the requester not granted last wins.
  function automatic logic pick_req(input logic v0, input logic v1, input logic last_grant);
    if (v0 && v1) begin
      return ~last_grant;
    end else if (v0) begin
      return REQ0;
    end else begin
      return REQ1;
    end
  endfunction

endpackage

// File: rtl/updn_counter_core.sv
// Up/down counter datapath: synchronous clear, enable-gated +/-1.
// Optional build macro: UPDN_ARB_SATURATE_EN (hold at the limits and flag them via at_limit).
module updn_counter_core
  import updn_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
`ifdef UPDN_ARB_SATURATE_EN
  output logic             at_limit,
`endif
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             hold;

`ifdef UPDN_ARB_SATURATE_EN
  // A step in the current direction would run past the top or bottom of the range.
  assign at_limit = (dir == DIR_UP) ? (q_q == '1) : (q_q == '0);
  assign hold     = at_limit;
`else
  assign hold = 1'b0;
`endif

  // Next counter value: clear wins over counting; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && !hold) begin
      q_d = (dir == DIR_UP) ? (q_q + One) : (q_q - One);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/updn_counter_arbiter.sv
// Two-requester round-robin front end for a shared up/down counter.
// Each accepted command runs to completion, then a one-cycle done pulse names its owner.
// Optional build macro: UPDN_ARB_SATURATE_EN (adds sat output; commands end early at a limit).
module updn_counter_arbiter
  import updn_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [STEPW-1:0] req0_steps,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [STEPW-1:0] req1_steps,
  output logic             req1_ready,
  input  logic             q_clear,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
`ifdef UPDN_ARB_SATURATE_EN
  output logic             sat,
`endif
  output logic             done_id
);

  localparam logic [STEPW-1:0] StepOne = STEPW'(1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
`ifdef UPDN_ARB_SATURATE_EN
  logic             sat_q, sat_d;
  logic             at_limit;
`endif

  logic             sel;
  logic             sel_dir;
  logic [STEPW-1:0] sel_steps;
  logic             cnt_en;
  logic             core_clr;
  logic             stop_early;

  assign sel       = pick_req(req0_valid, req1_valid, last_grant_q);
  assign sel_dir   = (sel == REQ1) ? req1_dir : req0_dir;
  assign sel_steps = (sel == REQ1) ? req1_steps : req0_steps;

`ifdef UPDN_ARB_SATURATE_EN
  assign stop_early = at_limit;
`else
  assign stop_early = 1'b0;
`endif

  // Arbitration, command latch and FSM next-state; readies only ever rise in idle.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    rem_d        = rem_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
`ifdef UPDN_ARB_SATURATE_EN
    sat_d        = sat_q;
`endif
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    cnt_en       = 1'b0;
    core_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        core_clr = q_clear;
        // A clear takes this cycle; any pending command is accepted on the next one.
        if (!q_clear && (req0_valid || req1_valid)) begin
          req0_ready   = (sel == REQ0);
          req1_ready   = (sel == REQ1);
          dir_d        = sel_dir;
          rem_d        = sel_steps;
          owner_d      = sel;
          last_grant_d = sel;
`ifdef UPDN_ARB_SATURATE_EN
          sat_d        = 1'b0;
`endif
          state_d      = (sel_steps == '0) ? StDone : StRun;
        end
      end

      StRun: begin
        if (stop_early) begin
          // Counter holds; command finishes without its remaining steps.
`ifdef UPDN_ARB_SATURATE_EN
          sat_d   = 1'b1;
`endif
          state_d = StDone;
        end else begin
          cnt_en = 1'b1;
          rem_d  = rem_q - StepOne;
          if (rem_q == StepOne) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and command registers; last_grant resets to REQ1 so REQ0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dir_q        <= DIR_DOWN;
      rem_q        <= '0;
      owner_q      <= REQ0;
      last_grant_q <= REQ1;
`ifdef UPDN_ARB_SATURATE_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      rem_q        <= rem_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
`ifdef UPDN_ARB_SATURATE_EN
      sat_q        <= sat_d;
`endif
    end
  end

  updn_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (core_clr),
    .en      (cnt_en),
    .dir     (dir_q),
`ifdef UPDN_ARB_SATURATE_EN
    .at_limit(at_limit),
`endif
    .q       (q)
  );

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign done_id = done & owner_q;
`ifdef UPDN_ARB_SATURATE_EN
  assign sat     = done & sat_q;
`endif

endmodule

// File: tb/tb_updn_counter_arbiter.sv
// Self-checking bench for updn_counter_arbiter: command table, arbitration, wrap,
// clear and mid-command reset sequences; done pulses are checked against a scoreboard.
module tb_updn_counter_arbiter;
  import updn_arb_pkg::*;

`ifdef UPDN_ARB_SATURATE_EN
  localparam bit SatMode = 1'b1;
`else
  localparam bit SatMode = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_dir, req0_ready;
  logic [7:0] req0_steps;
  logic       req1_valid, req1_dir, req1_ready;
  logic [7:0] req1_steps;
  logic       q_clear;
  logic [3:0] q;
  logic       busy, done, done_id;
`ifdef UPDN_ARB_SATURATE_EN
  logic       sat;
`endif

  updn_counter_arbiter #(
    .WIDTH(4),
    .STEPW(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_dir  (req0_dir),
    .req0_steps(req0_steps),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_dir  (req1_dir),
    .req1_steps(req1_steps),
    .req1_ready(req1_ready),
    .q_clear   (q_clear),
    .q         (q),
    .busy      (busy),
    .done      (done),
`ifdef UPDN_ARB_SATURATE_EN
    .sat       (sat),
`endif
    .done_id   (done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    bit         dir;
    int         steps;
    logic [3:0] exp_q;
  } vec_t;

  typedef struct {
    bit         id;
    logic [3:0] q;
    bit         sat;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        mon_e;
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one command from a known start value.
  function automatic void predict(input logic [3:0] q0, input bit dir, input int steps,
                                  output logic [3:0] qf, output bit sf);
    qf = q0;
    sf = 1'b0;
    for (int i = 0; i < steps; i++) begin
      if (SatMode && ((dir && qf == 4'hF) || (!dir && qf == 4'h0))) begin
        sf = 1'b1;
        break;
      end
      qf = dir ? qf + 4'd1 : qf - 4'd1;
    end
  endfunction

  task automatic drive_req(input bit id, input bit v, input bit dir, input int steps);
    if (id == 1'b0) begin
      req0_valid = v;
      req0_dir   = dir;
      req0_steps = steps[7:0];
    end else begin
      req1_valid = v;
      req1_dir   = dir;
      req1_steps = steps[7:0];
    end
  endtask

  // Waits for the named ready; cycles reports how many negedges it took.
  task automatic wait_accept(input bit id, output bit ok, output int cycles);
    ok     = 1'b0;
    cycles = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cycles++;
      if ((id == 1'b0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // One command with a cycle-accurate trace of q/busy/done.
  task automatic cmd(input bit id, input bit dir, input int steps, input bit pre_driven,
                     input bit clr_mid, output int acc_cycles);
    logic [3:0] mq, pq;
    bit         ps, ok, in_done;
    int         rem;
    if (!pre_driven) begin
      @(posedge clk);
      #1;
      drive_req(id, 1'b1, dir, steps);
    end
    wait_accept(id, ok, acc_cycles);
    if (!ok) begin
      drive_req(id, 1'b0, dir, 0);
      return;
    end
    predict(model_q, dir, steps, pq, ps);
    sb_q.push_back('{id: id, q: pq, sat: ps});
    @(posedge clk);
    #1;
    drive_req(id, 1'b0, dir, 0);
    mq      = model_q;
    rem     = steps;
    in_done = (steps == 0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      check("trace_q", q, mq);
      check("trace_busy", busy, 1);
      check("trace_done", done, in_done);
      check("ready_while_busy", req0_ready | req1_ready, 0);
      if (clr_mid) q_clear = (k == 2);
      if (in_done) break;
      if (SatMode && ((dir && mq == 4'hF) || (!dir && mq == 4'h0))) begin
        in_done = 1'b1;
      end else begin
        mq  = dir ? mq + 4'd1 : mq - 4'd1;
        rem = rem - 1;
        if (rem == 0) in_done = 1'b1;
      end
    end
    q_clear = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    model_q = pq;
  endtask

  // Both requesters raise valid together; checks grant order and mutual exclusion.
  task automatic dual(input bit d0, input int s0, input bit d1, input int s1,
                      input int exp_first);
    logic [3:0] pq;
    bit         ps;
    bit         got0, got1;
    int         first;
    got0  = 1'b0;
    got1  = 1'b0;
    first = -1;
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b1, d0, s0);
    drive_req(1'b1, 1'b1, d1, s1);
    for (int c = 0; c < 100 && !(got0 && got1); c++) begin
      @(negedge clk);
      check("ready_excl", req0_ready & req1_ready, 0);
      check("ready_while_busy", busy & (req0_ready | req1_ready), 0);
      if (req0_ready && !got0) begin
        got0 = 1'b1;
        if (first < 0) first = 0;
        predict(model_q, d0, s0, pq, ps);
        sb_q.push_back('{id: 1'b0, q: pq, sat: ps});
        model_q = pq;
      end
      if (req1_ready && !got1) begin
        got1 = 1'b1;
        if (first < 0) first = 1;
        predict(model_q, d1, s1, pq, ps);
        sb_q.push_back('{id: 1'b1, q: pq, sat: ps});
        model_q = pq;
      end
      @(posedge clk);
      #1;
      if (got0) req0_valid = 1'b0;
      if (got1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_first", first, exp_first);
    check("arb_both_served", {31'd0, got0 & got1}, 1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("arb_idle", busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    model_q = 4'h0;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_id", done_id, mon_e.id);
        check("done_q", q, mon_e.q);
`ifdef UPDN_ARB_SATURATE_EN
        check("done_sat", sat, mon_e.sat);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached expected test completion");
    $fatal(1);
  end

  vec_t vecs[5];
  int   acc;
  bit   ok;

  initial begin
    vecs[0] = '{id: 1'b0, dir: DIR_UP,   steps: 5, exp_q: 4'h5};
    vecs[1] = '{id: 1'b1, dir: DIR_UP,   steps: 3, exp_q: 4'h8};
    vecs[2] = '{id: 1'b0, dir: DIR_DOWN, steps: 2, exp_q: 4'h6};
    vecs[3] = '{id: 1'b1, dir: DIR_UP,   steps: 0, exp_q: 4'h6};
    vecs[4] = '{id: 1'b0, dir: DIR_DOWN, steps: 6, exp_q: 4'h0};

    reset   = 1'b1;
    q_clear = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 0);
    drive_req(1'b1, 1'b0, 1'b0, 0);
    model_q = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Command table from reset, including a zero-step command.
    for (int i = 0; i < 5; i++) begin
      cmd(vecs[i].id, vecs[i].dir, vecs[i].steps, 1'b0, 1'b0, acc);
      check("vec_q", q, vecs[i].exp_q);
    end

    // Tie after reset goes to requester 0, then requester 1.
    do_reset();
    dual(DIR_UP, 3, DIR_DOWN, 2, 0);
    check("arb_q", q, 4'h1);
    // After a requester-0 grant, a tie goes to requester 1.
    cmd(1'b0, DIR_UP, 1, 1'b0, 1'b0, acc);
    dual(DIR_UP, 2, DIR_DOWN, 1, 1);
    check("arb2_q", q, 4'h3);

    // Down through zero: wraps, or stops early with sat when saturating.
    do_reset();
    cmd(1'b0, DIR_UP, 2, 1'b0, 1'b0, acc);
    check("pre_wrap_q", q, 4'h2);
    cmd(1'b1, DIR_DOWN, 4, 1'b0, 1'b0, acc);
    check("wrap_q", q, SatMode ? 4'h0 : 4'hE);

    // Up through the top as well.
    cmd(1'b0, DIR_UP, 20, 1'b0, 1'b0, acc);

    // Clear alongside a valid: ready held off for one cycle, then accepted from q=0.
    @(posedge clk);
    #1;
    q_clear = 1'b1;
    drive_req(1'b0, 1'b1, DIR_UP, 4);
    @(negedge clk);
    check("clr_ready0", req0_ready, 0);
    check("clr_q_before", q, model_q);
    @(posedge clk);
    #1;
    q_clear = 1'b0;
    model_q = 4'h0;
    cmd(1'b0, DIR_UP, 4, 1'b1, 1'b1, acc);
    check("clr_accept_lat", acc, 1);
    check("clr_run_q", q, 4'h4);

    // Reset during the third step of a ten-step command: no done, back to idle at zero.
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b1, DIR_UP, 10);
    wait_accept(1'b0, ok, acc);
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, DIR_UP, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_pre_q", q, model_q + 4'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    model_q = 4'h0;
    @(negedge clk);
    check("rst_mid_q", q, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 0);
    end
    cmd(1'b1, DIR_UP, 2, 1'b0, 1'b0, acc);
    check("post_rst_q", q, 4'h2);

    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
